// File: rtl/forney.sv
// Forney error-magnitude evaluator for RS(255,247), t = 4, GF(2^8) with field polynomial 0x11D.
// Emits one (location, magnitude) pulse every 9 cycles, after a 4-cycle omega build.
module forney (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] error_num,
  input  logic [7:0] syn1,
  input  logic [7:0] syn2,
  input  logic [7:0] syn3,
  input  logic [7:0] syn4,
  input  logic [7:0] syn5,
  input  logic [7:0] syn6,
  input  logic [7:0] syn7,
  input  logic [7:0] syn8,
  input  logic [7:0] elp0,
  input  logic [7:0] elp1,
  input  logic [7:0] elp2,
  input  logic [7:0] elp3,
  input  logic [7:0] elp4,
  input  logic [7:0] el1,
  input  logic [7:0] el2,
  input  logic [7:0] el3,
  input  logic [7:0] el4,
  input  logic [7:0] gf_el1,
  input  logic [7:0] gf_el2,
  input  logic [7:0] gf_el3,
  input  logic [7:0] gf_el4,
  output logic       err_valid,
  output logic [7:0] err_loc,
  output logic [7:0] err_mag,
  output logic [1:0] err_idx,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  typedef enum logic [2:0] {S_IDLE, S_OMEGA, S_EVAL, S_INV, S_MUL} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1D) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] num_q, num_d;
  logic [7:0] syn_q [4];
  logic [7:0] syn_d [4];
  logic [7:0] elp_q [4];
  logic [7:0] elp_d [4];
  logic [7:0] el_q [4];
  logic [7:0] el_d [4];
  logic [7:0] gfe_q [4];
  logic [7:0] gfe_d [4];
  logic [7:0] omega_q [4];
  logic [7:0] omega_d [4];
  logic [7:0] omg_val_q, omg_val_d;
  logic [7:0] sq_q, sq_d;
  logic [7:0] acc_q, acc_d;
  logic       err_valid_q, err_valid_d;
  logic [7:0] err_loc_q, err_loc_d;
  logic [7:0] err_mag_q, err_mag_d;
  logic [1:0] err_idx_q, err_idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;

  logic [7:0] om_s;
  logic [7:0] x_s;
  logic [7:0] omg_s;
  logic [7:0] dp_s;

  // Only S1..S4 and Lambda0..3 contribute to omega0..3 and Lambda'
  logic unused_inputs;
  assign unused_inputs = ^{syn5, syn6, syn7, syn8, elp4};

  always_comb begin
    om_s = 8'h00;
    for (int j = 0; j < 4; j++) begin
      if (j <= int'(cnt_q)) om_s = om_s ^ gf_mul(syn_q[cnt_q[1:0] - 2'(j)], elp_q[j]);
      else                  om_s = om_s;
    end
  end

  assign x_s   = gfe_q[idx_q];
  assign omg_s = gf_mul(gf_mul(gf_mul(omega_q[3], x_s) ^ omega_q[2], x_s) ^ omega_q[1], x_s)
                 ^ omega_q[0];
  assign dp_s  = elp_q[1] ^ gf_mul(elp_q[3], gf_mul(x_s, x_s));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    num_d       = num_q;
    syn_d       = syn_q;
    elp_d       = elp_q;
    el_d        = el_q;
    gfe_d       = gfe_q;
    omega_d     = omega_q;
    omg_val_d   = omg_val_q;
    sq_d        = sq_q;
    acc_d       = acc_q;
    err_valid_d = 1'b0;
    err_loc_d   = err_loc_q;
    err_mag_d   = err_mag_q;
    err_idx_d   = err_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fail_d      = fail_q;
    if (start) begin
      syn_d = '{syn1, syn2, syn3, syn4};
      elp_d = '{elp0, elp1, elp2, elp3};
      el_d  = '{el1, el2, el3, el4};
      gfe_d = '{gf_el1, gf_el2, gf_el3, gf_el4};
      num_d = error_num;
      cnt_d = 3'd0;
      idx_d = 2'd0;
      if (error_num == 3'd0 || error_num > 3'd4) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        fail_d  = (error_num > 3'd4);
        busy_d  = 1'b0;
      end else begin
        state_d = S_OMEGA;
        fail_d  = 1'b0;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_OMEGA: begin
          omega_d[cnt_q[1:0]] = om_s;
          if (cnt_q == 3'd3) begin
            state_d = S_EVAL;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_EVAL: begin
          omg_val_d = omg_s;
          sq_d      = gf_mul(dp_s, dp_s);
          acc_d     = 8'h01;
          cnt_d     = 3'd0;
          if (dp_s == 8'h00) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            fail_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_INV;
          end
        end
        // Seven square-and-multiply steps accumulate d^(2+4+...+128) = d^254 = 1/d
        S_INV: begin
          acc_d = gf_mul(acc_q, sq_q);
          sq_d  = gf_mul(sq_q, sq_q);
          if (cnt_q == 3'd6) begin
            state_d = S_MUL;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_MUL: begin
          err_mag_d   = gf_mul(omg_val_q, acc_q);
          err_loc_d   = el_q[idx_q];
          err_idx_d   = idx_q;
          err_valid_d = 1'b1;
          if (({1'b0, idx_q} + 3'd1) == num_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_EVAL;
            idx_d   = idx_q + 2'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      idx_q       <= 2'd0;
      num_q       <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        syn_q[i]   <= 8'h00;
        elp_q[i]   <= 8'h00;
        el_q[i]    <= 8'h00;
        gfe_q[i]   <= 8'h00;
        omega_q[i] <= 8'h00;
      end
      omg_val_q   <= 8'h00;
      sq_q        <= 8'h00;
      acc_q       <= 8'h00;
      err_valid_q <= 1'b0;
      err_loc_q   <= 8'h00;
      err_mag_q   <= 8'h00;
      err_idx_q   <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      syn_q       <= syn_d;
      elp_q       <= elp_d;
      el_q        <= el_d;
      gfe_q       <= gfe_d;
      omega_q     <= omega_d;
      omg_val_q   <= omg_val_d;
      sq_q        <= sq_d;
      acc_q       <= acc_d;
      err_valid_q <= err_valid_d;
      err_loc_q   <= err_loc_d;
      err_mag_q   <= err_mag_d;
      err_idx_q   <= err_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_loc   = err_loc_q;
  assign err_mag   = err_mag_q;
  assign err_idx   = err_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_forney.sv
// Scoreboard bench for forney: stimulus pushes expected pulses (with their cycle), a monitor pops on err_valid/done.
module tb_forney;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] error_num;
  logic [7:0] syn_v [8];
  logic [7:0] elp_v [5];
  logic [7:0] el_v [4];
  logic [7:0] gel_v [4];
  logic       err_valid;
  logic [7:0] err_loc;
  logic [7:0] err_mag;
  logic [1:0] err_idx;
  logic       busy;
  logic       done;
  logic       fail;

  forney dut (
    .clk(clk), .rst(rst), .start(start), .error_num(error_num),
    .syn1(syn_v[0]), .syn2(syn_v[1]), .syn3(syn_v[2]), .syn4(syn_v[3]),
    .syn5(syn_v[4]), .syn6(syn_v[5]), .syn7(syn_v[6]), .syn8(syn_v[7]),
    .elp0(elp_v[0]), .elp1(elp_v[1]), .elp2(elp_v[2]), .elp3(elp_v[3]), .elp4(elp_v[4]),
    .el1(el_v[0]), .el2(el_v[1]), .el3(el_v[2]), .el4(el_v[3]),
    .gf_el1(gel_v[0]), .gf_el2(gel_v[1]), .gf_el3(gel_v[2]), .gf_el4(gel_v[3]),
    .err_valid(err_valid), .err_loc(err_loc), .err_mag(err_mag), .err_idx(err_idx),
    .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int t0    = 0;
  int ta    = 0;

  typedef struct { int cyc; logic [7:0] loc; logic [7:0] mag; logic [1:0] idx; } ev_t;
  typedef struct { int cyc; logic fail; } dn_t;
  ev_t ev_q [$];
  dn_t dn_q [$];
  ev_t mon_e;
  dn_t mon_d;

  logic [7:0] exp_t [256];
  int         log_t [256];
  int         pos_v [4] = '{3, 50, 100, 200};
  logic [7:0] mag_v [4] = '{8'h11, 8'h22, 8'h5C, 8'hE7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Log/antilog multiply: an independent route to the same field as the design's shift-and-add.
  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  always @(negedge clk) begin
    if (err_valid === 1'b1) begin
      if (ev_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_err_valid: got pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = ev_q.pop_front();
        chk("err_valid_cycle", cyc, mon_e.cyc);
        chk("err_loc", {24'h0, err_loc}, {24'h0, mon_e.loc});
        chk("err_mag", {24'h0, err_mag}, {24'h0, mon_e.mag});
        chk("err_idx", {30'h0, err_idx}, {30'h0, mon_e.idx});
      end
    end
    if (done === 1'b1) begin
      if (dn_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got pulse at cycle %0d, required none", cyc);
      end else begin
        mon_d = dn_q.pop_front();
        chk("done_cycle", cyc, mon_d.cyc);
        chk("done_fail", {31'h0, fail}, {31'h0, mon_d.fail});
      end
    end
  end

  task automatic push_ev(input int c, input logic [7:0] loc, input logic [7:0] mag, input logic [1:0] idx);
    ev_t e;
    e.cyc = c; e.loc = loc; e.mag = mag; e.idx = idx;
    ev_q.push_back(e);
  endtask

  task automatic push_dn(input int c, input logic f);
    dn_t d;
    d.cyc = c; d.fail = f;
    dn_q.push_back(d);
  endtask

  task automatic kick(input logic [2:0] n);
    @(negedge clk);
    error_num = n;
    start     = 1'b1;
    t0        = cyc;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 8; i++) syn_v[i] = 8'h00;
    for (int i = 0; i < 5; i++) elp_v[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin el_v[i] = 8'h00; gel_v[i] = 8'h00; end
  endtask

  task automatic set_single1();
    clear_vec();
    for (int i = 0; i < 8; i++) syn_v[i] = 8'h5A;
    elp_v[0] = 8'h01; elp_v[1] = 8'h01;
    gel_v[0] = 8'h01; el_v[0] = 8'h10;
  endtask

  task automatic set_four();
    logic [7:0] s;
    logic [7:0] xi;
    clear_vec();
    for (int j = 1; j <= 8; j++) begin
      s = 8'h00;
      for (int i = 0; i < 4; i++) s = s ^ tmul(mag_v[i], exp_t[(pos_v[i] * j) % 255]);
      syn_v[j-1] = s;
    end
    elp_v[0] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      xi = exp_t[pos_v[i]];
      for (int k = 4; k >= 1; k--) elp_v[k] = elp_v[k] ^ tmul(xi, elp_v[k-1]);
      gel_v[i] = exp_t[(255 - pos_v[i]) % 255];
      el_v[i]  = 8'(pos_v[i]);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_err_valid"}, {31'h0, err_valid}, 32'h0);
    chk({tag, "_err_loc"},   {24'h0, err_loc},   32'h0);
    chk({tag, "_err_mag"},   {24'h0, err_mag},   32'h0);
    chk({tag, "_err_idx"},   {30'h0, err_idx},   32'h0);
    chk({tag, "_busy"},      {31'h0, busy},      32'h0);
    chk({tag, "_done"},      {31'h0, done},      32'h0);
    chk({tag, "_fail"},      {31'h0, fail},      32'h0);
  endtask

  initial begin
    logic [7:0] v;
    exp_t[0] = 8'h01;
    log_t[0] = 0;
    log_t[1] = 0;
    for (int i = 1; i < 255; i++) begin
      v = exp_t[i-1];
      exp_t[i] = v[7] ? ({v[6:0], 1'b0} ^ 8'h1D) : {v[6:0], 1'b0};
      log_t[exp_t[i]] = i;
    end
    exp_t[255] = 8'h01;

    rst = 1'b1; start = 1'b0; error_num = 3'd0;
    clear_vec();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Single error at X = 1
    set_single1();
    kick(3'd1);
    push_ev(t0 + 14, 8'h10, 8'h5A, 2'd0);
    push_dn(t0 + 14, 1'b0);
    chk("busy_start", {31'h0, busy}, 32'h1);
    wait_to(t0 + 13);
    chk("busy_last", {31'h0, busy}, 32'h1);
    wait_to(t0 + 14);
    chk("busy_after", {31'h0, busy}, 32'h0);
    wait_to(t0 + 20);
    chk("err_loc_hold", {24'h0, err_loc}, 32'h10);

    // Single error at X = alpha; inputs scrambled after start must be ignored
    clear_vec();
    syn_v = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};
    elp_v[0] = 8'h01; elp_v[1] = 8'h02;
    gel_v[0] = 8'h8E; el_v[0] = 8'hFD;
    kick(3'd1);
    push_ev(t0 + 14, 8'hFD, 8'h01, 2'd0);
    push_dn(t0 + 14, 1'b0);
    for (int i = 0; i < 8; i++) syn_v[i] = 8'hFF;
    for (int i = 0; i < 5; i++) elp_v[i] = 8'h33;
    for (int i = 0; i < 4; i++) begin gel_v[i] = 8'h55; el_v[i] = 8'h77; end
    wait_to(t0 + 20);

    // Zero errors
    kick(3'd0);
    push_dn(t0 + 1, 1'b0);
    chk("busy_zero", {31'h0, busy}, 32'h0);
    wait_to(t0 + 5);

    // Degenerate locator: Lambda' = 0
    set_single1();
    elp_v[1] = 8'h00;
    kick(3'd1);
    push_dn(t0 + 6, 1'b1);
    wait_to(t0 + 10);
    chk("fail_held", {31'h0, fail}, 32'h1);
    chk("busy_after_fail", {31'h0, busy}, 32'h0);

    // Four errors
    set_four();
    kick(3'd4);
    chk("fail_cleared", {31'h0, fail}, 32'h0);
    for (int i = 0; i < 4; i++) push_ev(t0 + 14 + 9 * i, 8'(pos_v[i]), mag_v[i], 2'(i));
    push_dn(t0 + 41, 1'b0);
    wait_to(t0 + 45);

    // Too many errors
    kick(3'd5);
    push_dn(t0 + 1, 1'b1);
    wait_to(t0 + 5);

    // Abort: restart at cycle 20 of a four-error job
    set_four();
    kick(3'd4);
    ta = t0;
    push_ev(ta + 14, 8'(pos_v[0]), mag_v[0], 2'd0);
    wait_to(ta + 19);
    set_single1();
    kick(3'd1);
    chk("abort_start_cycle", t0, ta + 20);
    push_ev(t0 + 14, 8'h10, 8'h5A, 2'd0);
    push_dn(t0 + 14, 1'b0);
    wait_to(t0 + 18);

    // Reset in the middle of INV
    set_four();
    kick(3'd4);
    wait_to(t0 + 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");
    repeat (45) @(negedge clk);

    chk("pending_err_valid", ev_q.size(), 32'h0);
    chk("pending_done", dn_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forney.md
# forney

Error-magnitude evaluator for the RS(255,247) decoder (t = 4, GF(2^8), field polynomial 0x11D, α = 0x02, first consecutive root α^1). It sits directly downstream of the Chien search and upstream of the byte corrector. It takes:
- syndromes S1..S8;
- error-locator coefficients Λ0..Λ4;
- the Chien results: byte positions and the GF root X_i⁻¹ for each error.

It computes each error magnitude with the Forney algorithm, e_i = Ω(X_i⁻¹) / Λ'(X_i⁻¹), and emits one (location, magnitude) pulse per error.

## Interface
Parameters: none; field and t are fixed.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; samples all data inputs
- error_num  in  3  number of errors from the key-equation solver (0..4 valid)
- syn1..syn8  in  8 each  syndromes S_j = r(α^j)
- elp0..elp4  in  8 each  Λ(x) coefficients, elp0 = Λ0
- el1..el4  in  8 each  Chien byte positions, passed through unchanged
- gf_el1..gf_el4  in  8 each  Chien roots X_i⁻¹
- err_valid  out  1  one-cycle pulse; err_loc, err_mag, err_idx valid
- err_loc  out  8  byte position of the current error
- err_mag  out  8  error value to XOR into that byte
- err_idx  out  2  error index i−1 (0..3)
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- fail  out  1  uncorrectable; set with done, held until the next start

## Operation
- All inputs are captured into internal registers on start. Later input changes are ignored.
- States: IDLE → OMEGA → EVAL → INV → MUL → (EVAL for the next error | IDLE).
- IDLE, start with error_num = 0: go to IDLE; pulse done; no err_valid; fail = 0.
- IDLE, start with error_num > 4: pulse done with fail = 1.
- IDLE, start with error_num in 1..4: go to OMEGA.
- OMEGA, 4 cycles, one coefficient per cycle, k = 0..3: ω_k = Σ_{j=0..k} S_{k−j+1}·Λ_j.
- EVAL, 1 cycle, with x = X_i⁻¹:
  - Ω(x) = ω0 ^ ω1x ^ ω2x² ^ ω3x³, evaluated by Horner.
  - Λ'(x) = Λ1 ^ Λ3x² (odd terms only, characteristic 2).
  - Both results are registered.
  - If Λ'(x) = 0: go to IDLE, pulse done, set fail = 1, emit no further err_valid.
- INV, 7 cycles: inverse by x^254.
  - Initialise sq = d², acc = 1, where d = Λ'.
  - Each cycle: acc ← acc·sq, then sq ← sq².
- MUL, 1 cycle: err_mag ← Ω·acc, err_loc ← el_i, err_idx ← i−1.
  - err_valid is set in the next cycle.
  - If i = error_num, done is also set in that cycle and the state returns to IDLE; otherwise go to EVAL for i+1.
- All arithmetic is GF(2^8): addition is XOR; multiplication uses 0x11D reduction. No integer arithmetic except the state and error counters.
- A start in any non-IDLE state aborts the current job and restarts from the new inputs. No pending err_valid or done is emitted for the aborted job.
- rst returns to IDLE regardless of the current state.

## Timing
- Reset values: err_valid, err_loc, err_mag, err_idx, busy, done and fail are all 0; the state is IDLE.
- Timing reference: start is sampled at the edge ending cycle 0.
- error_num = 0 or > 4: done (and fail if set) is high in cycle 1; busy stays 0.
- error_num = N (1..4):
  - OMEGA occupies cycles 1–4.
  - Error i occupies EVAL at cycle 5+9(i−1), INV for the next 7 cycles, and MUL for 1 cycle.
  - err_valid for error i is high in cycle 5+9i, so the first error appears at cycle 14.
  - done is high in cycle 5+9N, coincident with the last err_valid; busy is high for cycles 1..5+9N−1.
- Λ' = 0 at error i: done and fail are high in the cycle after that EVAL, i.e. cycle 6+9(i−1).
- err_loc, err_mag and err_idx hold their values between pulses. Only err_valid qualifies them.
- There is no backpressure: the downstream block must accept one pulse every 9 cycles.

## Test plan
- Single error, X = 1: syn1..8 = 0x5A, elp = {01,01,00,00,00}, error_num = 1, gf_el1 = 0x01, el1 = 0x10 → err_valid in cycle 14 with err_loc = 0x10, err_mag = 0x5A, err_idx = 0; done in cycle 14; fail = 0.
- Single error, X = α: syn = {02,04,08,10,20,40,80,1D}, elp = {01,02,00,00,00}, gf_el1 = 0x8E, el1 = 0xFD → err_mag = 0x01, err_loc = 0xFD at cycle 14.
- Zero errors: error_num = 0 → done in cycle 1; no err_valid; busy stays 0; fail = 0.
- Degenerate locator: error_num = 1, elp = {01,00,00,00,00}, gf_el1 = 0x01 → done and fail in cycle 6; no err_valid.
- Four errors: syndromes and locator generated from four known (position, magnitude) pairs → four err_valid pulses at cycles 14, 23, 32, 41 with the matching values; done at cycle 41. Repeat with error_num = 5 → done and fail in cycle 1.
- Abort and reset: start a 4-error job, assert start with the single-error vector at cycle 20 → only the new result appears, 14 cycles later. Then assert rst mid-INV → all outputs 0 next cycle; no done.
